// File: rtl/snn_ff_pkg.sv
// -----------------------------------------------------------------------------
// snn_ff_pkg
// Shared types and default sizes for the post-neuron state SRAM controller.
//   state_e : controller FSM encoding (idle arbitration / clear sweep)
//   owner_e : which requester owns the read data returning next cycle
// -----------------------------------------------------------------------------
package snn_ff_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SRAM_DEPTH = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CFG  = 2'd1,
    OWN_NEUR = 2'd2,
    OWN_LRN  = 2'd3
  } owner_e;

endpackage

// File: rtl/post_neuron_sram_grant.sv
// -----------------------------------------------------------------------------
// post_neuron_sram_grant
// Combinational one-hot grant selection for the three SRAM requesters.
// Config always wins. Between neuron and learning engines, lrn_first picks
// who wins a contested cycle (tied low for plain neur > lrn priority).
// Ports:
//   arb_en                      : arbitration allowed this cycle
//   cfg_req/neur_req/lrn_req    : pending requests
//   lrn_first                   : learning engine wins a neur/lrn contest
//   cfg_gnt/neur_gnt/lrn_gnt    : at most one asserted
// -----------------------------------------------------------------------------
module post_neuron_sram_grant (
  input  logic arb_en,
  input  logic cfg_req,
  input  logic neur_req,
  input  logic lrn_req,
  input  logic lrn_first,
  output logic cfg_gnt,
  output logic neur_gnt,
  output logic lrn_gnt
);

  always_comb begin
    cfg_gnt  = 1'b0;
    neur_gnt = 1'b0;
    lrn_gnt  = 1'b0;
    if (arb_en) begin
      if (cfg_req) begin
        cfg_gnt = 1'b1;
      end else if (neur_req && lrn_req) begin
        if (lrn_first) lrn_gnt = 1'b1;
        else           neur_gnt = 1'b1;
      end else if (neur_req) begin
        neur_gnt = 1'b1;
      end else if (lrn_req) begin
        lrn_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/post_neuron_sram_arb.sv
// -----------------------------------------------------------------------------
// post_neuron_sram_arb
// Single-port access controller for the post-neuron state SRAM (registered
// read, 1-cycle latency). Shares the SRAM between config, neuron-update and
// learning engines, and runs a clear sweep writing INIT_VALUE to every word.
//
// Handshake: a requester raises req with its we/addr/wdata and holds them
// until gnt is seen in the same cycle; every cycle with gnt high is exactly one
// SRAM access. A read grant is answered by that port's rvalid one cycle later
// with rdata = sram_q; write grants return nothing.
//
// Ports:
//   CK, RST                         : clock, synchronous active-high reset
//   init_req/init_busy/init_done    : clear sweep start / in progress / done pulse
//   cfg_*, neur_*, lrn_*            : requester ports (lrn is read-only)
//   rdata                           : shared read data, valid with an rvalid
//   sram_cs/we/a/d, sram_q          : SRAM macro interface
//
// Build option: define POST_NEURON_ARB_RR_EN to round-robin neur and lrn
// at the second priority level (default: fixed neur > lrn).
// -----------------------------------------------------------------------------
module post_neuron_sram_arb
  import snn_ff_pkg::*;
#(
  parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                  SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  cfg_req,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic                  cfg_gnt,
  output logic                  cfg_rvalid,
  input  logic                  neur_req,
  input  logic                  neur_we,
  input  logic [ADDR_WIDTH-1:0] neur_addr,
  input  logic [DATA_WIDTH-1:0] neur_wdata,
  output logic                  neur_gnt,
  output logic                  neur_rvalid,
  input  logic                  lrn_req,
  input  logic [ADDR_WIDTH-1:0] lrn_addr,
  output logic                  lrn_gnt,
  output logic                  lrn_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  owner_e                  owner_q, owner_d;
  logic                    arb_en;
  logic                    lrn_first;

  // No access is issued while RST is high: this keeps a mid-sweep reset from
  // writing the word at the current counter, and drops any pending rvalid.
  assign arb_en = (state_q == ST_IDLE) && !init_req && !RST;

  post_neuron_sram_grant u_grant (
    .arb_en    (arb_en),
    .cfg_req   (cfg_req),
    .neur_req  (neur_req),
    .lrn_req   (lrn_req),
    .lrn_first (lrn_first),
    .cfg_gnt   (cfg_gnt),
    .neur_gnt  (neur_gnt),
    .lrn_gnt   (lrn_gnt)
  );

`ifdef POST_NEURON_ARB_RR_EN
  // Last neur/lrn winner; starts as "lrn last" so neur wins the first contest.
  logic lrn_last_q, lrn_last_d;

  always_comb begin
    lrn_last_d = lrn_last_q;
    if (neur_gnt || lrn_gnt) lrn_last_d = lrn_gnt;
  end

  always_ff @(posedge CK) begin
    if (RST) lrn_last_q <= 1'b1;
    else     lrn_last_q <= lrn_last_d;
  end

  assign lrn_first = !lrn_last_q;
`else
  assign lrn_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    owner_d     = OWN_NONE;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    sram_a      = '0;
    sram_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (cfg_gnt) begin
          sram_cs = 1'b1;
          sram_we = cfg_we;
          sram_a  = cfg_addr;
          sram_d  = cfg_wdata;
          owner_d = cfg_we ? OWN_NONE : OWN_CFG;
        end else if (neur_gnt) begin
          sram_cs = 1'b1;
          sram_we = neur_we;
          sram_a  = neur_addr;
          sram_d  = neur_wdata;
          owner_d = neur_we ? OWN_NONE : OWN_NEUR;
        end else if (lrn_gnt) begin
          sram_cs = 1'b1;
          sram_a  = lrn_addr;
          owner_d = OWN_LRN;
        end
      end
      ST_INIT: begin
        sram_cs = !RST;
        sram_we = !RST;
        sram_a  = cnt_q;
        sram_d  = INIT_VALUE;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      owner_q     <= OWN_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      owner_q     <= owner_d;
    end
  end

  assign init_busy   = (state_q == ST_INIT);
  assign init_done   = init_done_q;
  assign cfg_rvalid  = (owner_q == OWN_CFG)  && !RST;
  assign neur_rvalid = (owner_q == OWN_NEUR) && !RST;
  assign lrn_rvalid  = (owner_q == OWN_LRN)  && !RST;
  assign rdata       = sram_q;

endmodule

// File: tb/tb_post_neuron_sram_arb.sv
module tb_post_neuron_sram_arb;

  logic        CK = 1'b0;
  logic        RST;
  logic        init_req, init_busy, init_done;
  logic        cfg_req, cfg_we, cfg_gnt, cfg_rvalid;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        neur_req, neur_we, neur_gnt, neur_rvalid;
  logic [7:0]  neur_addr;
  logic [31:0] neur_wdata;
  logic        lrn_req, lrn_gnt, lrn_rvalid;
  logic [7:0]  lrn_addr;
  logic [31:0] rdata;
  logic        sram_cs, sram_we;
  logic [7:0]  sram_a;
  logic [31:0] sram_d, sram_q;

  int n_chk = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 CK = ~CK;

  // ---------------- SRAM model (256 x 32, registered read) ----------------
  logic [31:0] mem [0:255];
  logic        preload_en;

  always @(posedge CK) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_d;
      else         sram_q <= mem[sram_a];
    end
  end

  post_neuron_sram_arb dut (
    .CK(CK), .RST(RST),
    .init_req(init_req), .init_busy(init_busy), .init_done(init_done),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid),
    .neur_req(neur_req), .neur_we(neur_we), .neur_addr(neur_addr), .neur_wdata(neur_wdata),
    .neur_gnt(neur_gnt), .neur_rvalid(neur_rvalid),
    .lrn_req(lrn_req), .lrn_addr(lrn_addr), .lrn_gnt(lrn_gnt), .lrn_rvalid(lrn_rvalid),
    .rdata(rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_all();
    init_req = 1'b0;
    cfg_req  = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    neur_req = 1'b0; neur_we = 1'b0; neur_addr = '0; neur_wdata = '0;
    lrn_req  = 1'b0; lrn_addr = '0;
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data, input string tag);
    @(negedge CK);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    #1;
    chk({tag, "_gnt"}, 32'(cfg_gnt), 1);
    @(negedge CK);
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    @(negedge CK);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = addr;
    #1;
    chk({tag, "_gnt"}, 32'(cfg_gnt), 1);
    @(negedge CK);
    cfg_req = 1'b0;
    #1;
    chk({tag, "_rv"}, 32'(cfg_rvalid), 1);
    chk({tag, "_rd"}, rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int err, busy_n, done_n, done_at, idx, ng, lg, seq_err, g_err;
    logic seen, exp_n;

    drop_all();
    RST = 1'b1;
    preload_en = 1'b1;
    repeat (3) @(negedge CK);
    RST = 1'b0;
    preload_en = 1'b0;
    #1;
    chk("rst_busy", 32'(init_busy), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_rvalid", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 0);
    chk("rst_cs", 32'(sram_cs), 0);

    // ---- sweep aborted by RST at sweep cycle 100 ----
    @(negedge CK);
    init_req = 1'b1; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h00;
    #1;
    chk("initreq_beats_cfg", 32'(cfg_gnt), 0);
    chk("initreq_no_access", 32'(sram_cs), 0);
    @(negedge CK);
    init_req = 1'b0; cfg_req = 1'b0;
    err = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!(sram_cs && sram_we && sram_a == 8'(k) && sram_d == 32'h0 && init_busy)) err++;
      @(negedge CK);
    end
    chk("abort_sweep_writes", err, 0);
    RST = 1'b1;
    #1;
    chk("abort_no_write", 32'(sram_cs), 0);
    @(negedge CK);
    RST = 1'b0;
    #1;
    chk("abort_busy", 32'(init_busy), 0);
    chk("abort_done", 32'(init_done), 0);
    cfg_read(8'd99,  32'h0000_0000, "abort_w99");
    cfg_read(8'd100, 32'hA500_0064, "abort_w100");
    cfg_read(8'd255, 32'hA500_00FF, "abort_w255");
    cfg_read(8'd0,   32'h0000_0000, "abort_w0");

    // ---- full sweep ----
    @(negedge CK);
    init_req = 1'b1;
    @(negedge CK);
    init_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; idx = 0; err = 0;
    for (int c = 1; c <= 300; c++) begin
      #1;
      if (init_busy) begin
        busy_n++;
        if (!(sram_cs && sram_we && sram_a == 8'(idx) && sram_d == 32'h0)) err++;
        idx++;
      end
      if (init_done) begin
        done_n++;
        done_at = c;
      end
      @(negedge CK);
    end
    chk("sweep_busy_cycles", busy_n, 256);
    chk("sweep_addr_seq", err, 0);
    chk("sweep_done_pulses", done_n, 1);
    chk("sweep_done_cycle", done_at, 257);
    cfg_read(8'h00, 32'h0, "sweep_rd00");
    cfg_read(8'hFF, 32'h0, "sweep_rdff");
    cfg_read(8'h64, 32'h0, "sweep_rd64");

    // ---- write then read next cycle ----
    @(negedge CK);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h12; cfg_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr12_gnt", 32'(cfg_gnt), 1);
    chk("wr12_we", 32'(sram_we), 1);
    @(negedge CK);
    cfg_we = 1'b0;
    #1;
    chk("rd12_gnt", 32'(cfg_gnt), 1);
    chk("wr12_no_rvalid", 32'(cfg_rvalid), 0);
    @(negedge CK);
    cfg_req = 1'b0;
    #1;
    chk("rd12_rv", 32'(cfg_rvalid), 1);
    chk("rd12_rd", rdata, 32'hDEAD_BEEF);

    // ---- three requesters at once ----
    cfg_write(8'h20, 32'h1111_1111, "w20");
    cfg_write(8'h21, 32'h2222_2222, "w21");
    cfg_write(8'h22, 32'h3333_3333, "w22");
    @(negedge CK);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h20;
    neur_req = 1'b1; neur_we = 1'b0; neur_addr = 8'h21;
    lrn_req = 1'b1; lrn_addr = 8'h22;
    #1;
    chk("tri_c1_gnt", 32'({cfg_gnt, neur_gnt, lrn_gnt}), 32'b100);
    @(negedge CK);
    cfg_req = 1'b0;
    #1;
    chk("tri_c2_gnt", 32'({cfg_gnt, neur_gnt, lrn_gnt}), 32'b010);
    chk("tri_c2_rv", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 32'b100);
    chk("tri_c2_rd", rdata, 32'h1111_1111);
    @(negedge CK);
    neur_req = 1'b0;
    #1;
    chk("tri_c3_gnt", 32'({cfg_gnt, neur_gnt, lrn_gnt}), 32'b001);
    chk("tri_c3_rv", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 32'b010);
    chk("tri_c3_rd", rdata, 32'h2222_2222);
    @(negedge CK);
    lrn_req = 1'b0;
    #1;
    chk("tri_c4_rv", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 32'b001);
    chk("tri_c4_rd", rdata, 32'h3333_3333);
    @(negedge CK);
    #1;
    chk("tri_c5_rv", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 0);

    // ---- neur and lrn contending for 8 cycles ----
    @(negedge CK);
    neur_req = 1'b1; neur_we = 1'b0; neur_addr = 8'h21;
    lrn_req = 1'b1; lrn_addr = 8'h22;
    ng = 0; lg = 0; seq_err = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
`ifdef POST_NEURON_ARB_RR_EN
      exp_n = (c % 2 == 0);
`else
      exp_n = 1'b1;
`endif
      if (neur_gnt) ng++;
      if (lrn_gnt) lg++;
      if (neur_gnt !== exp_n || lrn_gnt !== !exp_n) seq_err++;
      @(negedge CK);
    end
    neur_req = 1'b0; lrn_req = 1'b0;
    #1;
`ifdef POST_NEURON_ARB_RR_EN
    chk("cont_neur_gnts", ng, 4);
    chk("cont_lrn_gnts", lg, 4);
    chk("cont_last_rv", 32'({neur_rvalid, lrn_rvalid}), 32'b01);
`else
    chk("cont_neur_gnts", ng, 8);
    chk("cont_lrn_gnts", lg, 0);
    chk("cont_last_rv", 32'({neur_rvalid, lrn_rvalid}), 32'b10);
`endif
    chk("cont_sequence", seq_err, 0);

    // ---- neuron write, learning read of the same word ----
    @(negedge CK);
    neur_req = 1'b1; neur_we = 1'b1; neur_addr = 8'h30; neur_wdata = 32'hCAFE_F00D;
    #1;
    chk("nw_gnt", 32'(neur_gnt), 1);
    @(negedge CK);
    neur_req = 1'b0; neur_we = 1'b0;
    lrn_req = 1'b1; lrn_addr = 8'h30;
    #1;
    chk("lr_gnt", 32'(lrn_gnt), 1);
    chk("nw_no_rvalid", 32'(neur_rvalid), 0);
    @(negedge CK);
    lrn_req = 1'b0;
    #1;
    chk("lr_rv", 32'(lrn_rvalid), 1);
    chk("lr_rd", rdata, 32'hCAFE_F00D);

    // ---- requests held through a sweep ----
    @(negedge CK);
    init_req = 1'b1;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h12;
    neur_req = 1'b1; neur_we = 1'b0; neur_addr = 8'h30;
    lrn_req = 1'b1; lrn_addr = 8'h22;
    #1;
    g_err = 0;
    if (cfg_gnt || neur_gnt || lrn_gnt) g_err++;
    @(negedge CK);
    init_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      #1;
      if (init_done) seen = 1'b1;
      else begin
        if (cfg_gnt || neur_gnt || lrn_gnt) g_err++;
        @(negedge CK);
      end
    end
    chk("held_done_seen", 32'(seen), 1);
    chk("held_no_gnt_in_sweep", g_err, 0);
    // FSM is back in IDLE while init_done is high, so arbitration resumes here.
    chk("held_first_gnt", 32'({cfg_gnt, neur_gnt, lrn_gnt}), 32'b100);
    @(negedge CK);
    cfg_req = 1'b0;
    #1;
    chk("held_cfg_rv", 32'(cfg_rvalid), 1);
    chk("held_cfg_rd", rdata, 32'h0);
    chk("held_next_gnt", 32'({cfg_gnt, neur_gnt, lrn_gnt}), 32'b010);
    @(negedge CK);
    drop_all();

    // ---- RST right after a read grant drops the pending rvalid ----
    @(negedge CK);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h20;
    #1;
    chk("rstrd_gnt", 32'(cfg_gnt), 1);
    @(negedge CK);
    cfg_req = 1'b0;
    RST = 1'b1;
    #1;
    chk("rstrd_rv_in_rst", 32'(cfg_rvalid), 0);
    @(negedge CK);
    RST = 1'b0;
    #1;
    chk("rstrd_rv_after", 32'({cfg_rvalid, neur_rvalid, lrn_rvalid}), 0);
    chk("rstrd_busy", 32'(init_busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
